lbp_histogram: RTL and testbench

- Downstream consumer of the LBP feature stage.
- Accepts the per-pixel LBP stream (lbp_valid/lbp_addr/lbp_data/finish) and builds a 256-bin histogram of LBP codes over interior pixels.
- After the frame ends, drains the bins in order 0..255 over a valid/ready interface to the descriptor/output logic.
- Counter storage is a register array, which allows whole-array asynchronous clear.

---
 rtl/lbp_histogram.sv | 116 +++++++++++
 tb/tb_lbp_histogram.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_histogram.sv
// rtl/lbp_histogram.sv - 256-bin LBP code histogram with ordered valid/ready drain
// Two-stage pixel path (capture, then single-cycle read-modify-write) feeding a register-array histogram.
module lbp_histogram #(
  parameter int ADDR_W = 14,
  parameter int CODE_W = 8,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [CODE_W-1:0] lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [CODE_W-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_last,
  output logic [ADDR_W-1:0] pix_count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int NBINS = 1 << CODE_W;
  localparam int HALF  = ADDR_W / 2;

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                s_valid_q, s_valid_d;
  logic [CODE_W-1:0]   s_code_q, s_code_d;
  logic                s_border_q, s_border_d;
  logic [CNT_W-1:0]    bin_q [NBINS];
  logic [CNT_W-1:0]    bin_d [NBINS];
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [1:0]          err_q, err_d;
  logic                hist_valid_q, hist_valid_d;
  logic [CODE_W-1:0]   hist_bin_q, hist_bin_d;

  logic [ADDR_W-HALF-1:0] row;
  logic [HALF-1:0]        col;
  logic                   commit;

  always_comb begin
    row        = lbp_addr[ADDR_W-1:HALF];
    col        = lbp_addr[HALF-1:0];
    // Only ACCUM accepts pixels; anything later is flagged rather than counted.
    s_valid_d  = lbp_valid && (state_q == ACCUM);
    s_code_d   = lbp_data;
    s_border_d = (row == '0) || (&row) || (col == '0) || (&col);

    commit = s_valid_q && !s_border_q;
    bin_d  = bin_q;
    pix_d  = pix_q;
    if (commit && !(&bin_q[s_code_q])) bin_d[s_code_q] = bin_q[s_code_q] + 1'b1;
    if (commit && !(&pix_q)) pix_d = pix_q + 1'b1;

    err_d = err_q | {lbp_valid && (state_q != ACCUM), s_valid_q && s_border_q};

    state_d      = state_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    case (state_q)
      ACCUM: if (finish) state_d = FLUSH;
      FLUSH: begin
        state_d      = DRAIN;
        hist_valid_d = 1'b1;
        hist_bin_d   = '0;
      end
      DRAIN: if (hist_ready) begin
        if (&hist_bin_q) begin
          state_d      = DONE;
          hist_valid_d = 1'b0;
        end else begin
          hist_bin_d = hist_bin_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ACCUM;
      s_valid_q    <= 1'b0;
      s_code_q     <= '0;
      s_border_q   <= 1'b0;
      for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
      pix_q        <= '0;
      err_q        <= '0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_valid_q    <= s_valid_d;
      s_code_q     <= s_code_d;
      s_border_q   <= s_border_d;
      bin_q        <= bin_d;
      pix_q        <= pix_d;
      err_q        <= err_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = bin_q[hist_bin_q];
  assign hist_last  = hist_valid_q && (&hist_bin_q);
  assign pix_count  = pix_q;
  assign busy       = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_lbp_histogram.sv
// tb/tb_lbp_histogram.sv - directed bench for lbp_histogram
// A second instance with 4-bit bins shares the stimulus to exercise bin saturation.
module tb_lbp_histogram;

  logic        clk;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;

  logic        hist_valid, hist_last, busy, done;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count_a, pix_count;
  logic [1:0]  err;

  logic        hist_valid_b, hist_last_b, busy_b, done_b;
  logic [7:0]  hist_bin_b;
  logic [3:0]  hist_count_b;
  logic [13:0] pix_count_b;
  logic [1:0]  err_b;

  int checks   = 0;
  int failures = 0;
  int beats;
  int lasts;
  int others;
  logic [15:0] got_a [256];
  logic [15:0] got_b [256];

  lbp_histogram #(.ADDR_W(14), .CODE_W(8), .CNT_W(14)) dut_a (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
    .hist_count(hist_count_a), .hist_last(hist_last), .pix_count(pix_count), .busy(busy),
    .done(done), .err(err)
  );

  lbp_histogram #(.ADDR_W(14), .CODE_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .hist_valid(hist_valid_b), .hist_ready(hist_ready), .hist_bin(hist_bin_b),
    .hist_count(hist_count_b), .hist_last(hist_last_b), .pix_count(pix_count_b), .busy(busy_b),
    .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit fin);
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = fin;
    hist_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hist_valid", hist_valid, 0);
    chk("rst_hist_bin", hist_bin, 0);
    chk("rst_hist_last", hist_last, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_after_reset", busy, 1);
  endtask

  task automatic send_pix(input int r, input int c, input logic [7:0] code);
    logic [6:0] rr, cc;
    rr        = r[6:0];
    cc        = c[6:0];
    lbp_valid = 1'b1;
    lbp_addr  = {rr, cc};
    lbp_data  = code;
    @(posedge clk);
    #1;
    lbp_valid = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int stop_bin, input bit late);
    int k, cyc, exp_bin;
    bit held, injected;
    logic [7:0]  hb;
    logic [13:0] hca;
    k = 0; cyc = 0; exp_bin = 0; held = 0; injected = 0; hb = '0; hca = '0;
    beats = 0; lasts = 0;
    for (int i = 0; i < 256; i++) begin
      got_a[i] = '0;
      got_b[i] = '0;
    end
    while (1) begin
      @(posedge clk);
      #1;
      lbp_valid = 1'b0;
      cyc++;
      if (cyc > 3000) begin
        chk("drain_timeout", 1, 0);
        break;
      end
      if (held) begin
        chk("hold_bin", hist_bin, hb);
        chk("hold_count", hist_count_a, hca);
        chk("hold_valid", hist_valid, 1);
        held = 0;
      end
      if (hist_valid) begin
        if (stop_bin >= 0 && int'(hist_bin) == stop_bin) begin
          reset      = 1'b1;
          hist_ready = 1'b0;
          return;
        end
        if (late && !injected && hist_bin == 8'd8) begin
          lbp_valid = 1'b1;
          lbp_addr  = {7'd5, 7'd5};
          lbp_data  = 8'h77;
          injected  = 1;
        end
        hist_ready = pat[k % 4];
        k++;
        if (hist_ready) begin
          chk("order", hist_bin, exp_bin);
          chk("last_flag", hist_last, hist_bin == 8'hFF);
          exp_bin++;
          got_a[hist_bin] = {2'b00, hist_count_a};
          got_b[hist_bin] = {12'h000, hist_count_b};
          beats++;
          if (hist_last) lasts++;
          if (hist_bin == 8'hFF) break;
        end else begin
          held = 1;
          hb   = hist_bin;
          hca  = hist_count_a;
        end
      end
    end
    @(posedge clk);
    #1;
    hist_ready = 1'b0;
    chk("valid_after_last", hist_valid, 0);
    chk("done_after_last", done, 1);
    chk("busy_in_done", busy, 0);
    chk("beats", beats, 256);
    chk("last_beats", lasts, 1);
  endtask

  task automatic count_others(input int skip0, input int skip1);
    others = 0;
    for (int i = 0; i < 256; i++)
      if (i != skip0 && i != skip1 && got_a[i] != 0) others++;
  endtask

  initial begin
    // Normal frame, ready held high.
    do_reset(1'b0);
    send_pix(1, 1, 8'h00);
    send_pix(1, 2, 8'h00);
    send_pix(1, 3, 8'hFF);
    finish = 1'b1;
    drain(4'b1111, -1, 1'b0);
    chk("f1_bin0", got_a[0], 2);
    chk("f1_bin255", got_a[255], 1);
    count_others(0, 255);
    chk("f1_others_zero", others, 0);
    chk("f1_pix_count", pix_count, 3);
    chk("f1_err", err, 0);

    // Same frame with ready pattern 1,0,0,1.
    do_reset(1'b0);
    send_pix(1, 1, 8'h00);
    send_pix(1, 2, 8'h00);
    send_pix(1, 3, 8'hFF);
    finish = 1'b1;
    drain(4'b1001, -1, 1'b0);
    chk("f2_bin0", got_a[0], 2);
    chk("f2_bin255", got_a[255], 1);
    count_others(0, 255);
    chk("f2_others_zero", others, 0);

    // Saturation: 20 hits on one code.
    do_reset(1'b0);
    for (int c = 1; c <= 20; c++) send_pix(2, c, 8'h5A);
    finish = 1'b1;
    drain(4'b1111, -1, 1'b0);
    chk("sat_bin_wide", got_a[8'h5A], 20);
    chk("sat_bin_narrow", got_b[8'h5A], 15);
    chk("sat_pix_wide", pix_count, 20);
    chk("sat_pix_narrow", pix_count_b, 20);

    // Border pixel, pixel coincident with finish, late pixel during drain.
    do_reset(1'b0);
    send_pix(0, 5, 8'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("border_err", err, 1);
    chk("border_pix", pix_count, 0);
    send_pix(3, 3, 8'h44);
    lbp_valid = 1'b1;
    lbp_addr  = {7'd4, 7'd4};
    lbp_data  = 8'h33;
    finish    = 1'b1;
    drain(4'b1111, -1, 1'b1);
    chk("late_bin22", got_a[8'h22], 0);
    chk("late_bin33", got_a[8'h33], 1);
    chk("late_bin44", got_a[8'h44], 1);
    chk("late_bin77", got_a[8'h77], 0);
    chk("late_pix", pix_count, 2);
    chk("late_err", err, 3);

    // Full interior sweep.
    do_reset(1'b0);
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++) send_pix(r, c, 8'h10);
    finish = 1'b1;
    drain(4'b1111, -1, 1'b0);
    chk("sweep_bin", got_a[8'h10], 15876);
    chk("sweep_bin_narrow", got_b[8'h10], 15);
    chk("sweep_pix", pix_count, 15876);
    count_others(16, 16);
    chk("sweep_others_zero", others, 0);

    // Reset mid-drain, then an empty frame with finish high at reset release.
    do_reset(1'b0);
    send_pix(10, 10, 8'h40);
    send_pix(0, 9, 8'h41);
    finish = 1'b1;
    drain(4'b1111, 40, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_hist_valid", hist_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_pix", pix_count, 0);
    chk("midrst_done", done, 0);
    do_reset(1'b1);
    drain(4'b1111, -1, 1'b0);
    count_others(-1, -1);
    chk("empty_all_zero", others, 0);
    chk("empty_pix", pix_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
